// File: rtl/bootram_loader.sv
// rtl/bootram_loader.sv - framed byte-stream loader that programs the boot RAM and holds the CPU in reset
module bootram_loader #(
    parameter int         RAM_AW         = 11,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [7:0]        ram_din,
    output logic              ram_own,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     RAM_SIZE = 17'(2 ** RAM_AW);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        LHI,
        LLO,
        DATA,
        CSUM
    } state_t;

    state_t            state, state_n;
    logic [7:0]        addr_hi, addr_hi_n;
    logic [RAM_AW-1:0] addr, addr_n;
    logic [7:0]        len_hi, len_hi_n;
    logic [15:0]       count, count_n;
    logic [7:0]        sum, sum_n;
    logic [TW-1:0]     tcnt, tcnt_n;

    logic              ram_ce_n, ram_wre_n, ram_own_n, cpu_hold_n, done_n;
    logic [RAM_AW-1:0] ram_ad_n;
    logic [7:0]        ram_din_n;
    logic [1:0]        err_code_n;

    logic [15:0]       len_full;
    logic [16:0]       end_addr;

    // Register all parser state and outputs; reset drops any pending write pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_hi  <= '0;
            addr     <= '0;
            len_hi   <= '0;
            count    <= '0;
            sum      <= '0;
            tcnt     <= '0;
            ram_ce   <= 1'b0;
            ram_wre  <= 1'b0;
            ram_ad   <= '0;
            ram_din  <= '0;
            ram_own  <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            addr_hi  <= addr_hi_n;
            addr     <= addr_n;
            len_hi   <= len_hi_n;
            count    <= count_n;
            sum      <= sum_n;
            tcnt     <= tcnt_n;
            ram_ce   <= ram_ce_n;
            ram_wre  <= ram_wre_n;
            ram_ad   <= ram_ad_n;
            ram_din  <= ram_din_n;
            ram_own  <= ram_own_n;
            cpu_hold <= cpu_hold_n;
            done     <= done_n;
            err_code <= err_code_n;
        end
    end

    // Packet parser: next state, write pulse generation, checksum and inter-byte timeout
    always_comb begin
        state_n    = state;
        addr_hi_n  = addr_hi;
        addr_n     = addr;
        len_hi_n   = len_hi;
        count_n    = count;
        sum_n      = sum;
        tcnt_n     = tcnt;
        ram_ce_n   = 1'b0;
        ram_wre_n  = 1'b0;
        ram_ad_n   = ram_ad;
        ram_din_n  = ram_din;
        ram_own_n  = ram_own;
        cpu_hold_n = cpu_hold;
        done_n     = done;
        err_code_n = err_code;

        len_full = {len_hi, in_data};
        end_addr = 17'(addr) + {1'b0, len_full};

        // Inter-byte timer only runs while a packet is open
        if (state == IDLE || in_valid) begin
            tcnt_n = '0;
        end else begin
            tcnt_n = tcnt + TW'(1);
        end

        case (state)
            IDLE: begin
                ram_own_n = 1'b0;
                if (in_valid && in_data == SYNC_BYTE) begin
                    ram_own_n  = 1'b1;
                    cpu_hold_n = 1'b1;
                    done_n     = 1'b0;
                    err_code_n = ERR_NONE;
                    sum_n      = '0;
                    state_n    = AHI;
                end
            end
            AHI: begin
                if (in_valid) begin
                    addr_hi_n = in_data;
                    state_n   = ALO;
                end
            end
            ALO: begin
                if (in_valid) begin
                    // Upper address bits beyond the RAM size are dropped
                    addr_n  = RAM_AW'({addr_hi, in_data});
                    state_n = LHI;
                end
            end
            LHI: begin
                if (in_valid) begin
                    len_hi_n = in_data;
                    state_n  = LLO;
                end
            end
            LLO: begin
                if (in_valid) begin
                    // 17-bit end address so a full-RAM load ending exactly at the top is legal
                    if (len_full != 16'd0 && end_addr <= RAM_SIZE) begin
                        count_n = len_full;
                        state_n = DATA;
                    end else begin
                        err_code_n = ERR_RANGE;
                        ram_own_n  = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            DATA: begin
                if (in_valid) begin
                    ram_ce_n  = 1'b1;
                    ram_wre_n = 1'b1;
                    ram_ad_n  = addr;
                    ram_din_n = in_data;
                    sum_n     = sum + in_data;
                    addr_n    = addr + RAM_AW'(1);
                    count_n   = count - 16'd1;
                    if (count == 16'd1) begin
                        state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                // No writes are issued here, so the port is released as soon as the last pulse ends
                ram_own_n = 1'b0;
                if (in_valid) begin
                    if (in_data == sum) begin
                        done_n     = 1'b1;
                        cpu_hold_n = 1'b0;
                        err_code_n = ERR_NONE;
                    end else begin
                        err_code_n = ERR_CSUM;
                    end
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Timeout abandons the packet; a pulse already registered still completes this cycle
        if (state != IDLE && !in_valid && tcnt == T_LAST) begin
            state_n    = IDLE;
            err_code_n = ERR_TIMEOUT;
            ram_own_n  = 1'b0;
            tcnt_n     = '0;
        end
    end

endmodule

// File: tb/tb_bootram_loader.sv
// tb/tb_bootram_loader.sv - self-checking bench for bootram_loader
module tb_bootram_loader;

    localparam int         AW   = 11;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          ram_ce, ram_wre, ram_own, cpu_hold, done;
    logic [AW-1:0] ram_ad;
    logic [7:0]    ram_din;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;

    typedef struct {
        logic [AW-1:0] ad;
        logic [7:0]    d;
        int            cyc;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic [7:0]  seed;
        logic        bad;
        logic [1:0]  eerr;
        logic        edone;
        logic        ehold;
    } vec_t;
    vec_t vecs[8];

    bootram_loader #(
        .RAM_AW(AW),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .ram_ce(ram_ce),
        .ram_wre(ram_wre),
        .ram_ad(ram_ad),
        .ram_din(ram_din),
        .ram_own(ram_own),
        .cpu_hold(cpu_hold),
        .done(done),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard: every write pulse must match the next expected {addr, data, cycle}
    always @(negedge clk) begin
        if (ram_wre) begin
            wr_t e;
            wr_count++;
            check("wr_expected", 32'(sb.size() != 0), 32'd1);
            check("wr_ce_own", {30'd0, ram_ce, ram_own}, 32'd3);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(ram_ad), 32'(e.ad));
                check("wr_data", 32'(ram_din), 32'(e.d));
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]    d, s;
        logic [AW-1:0] a;
        int            w0;
        bit            accept;
        w0 = wr_count;
        accept = (v.eerr != 2'b01);
        send_byte(SYNC);
        check("sync_flags", {27'd0, ram_own, cpu_hold, done, err_code}, 32'b11000);
        send_byte(v.addr[15:8]);
        send_byte(v.addr[7:0]);
        send_byte(v.len[15:8]);
        send_byte(v.len[7:0]);
        if (accept) begin
            a = v.addr[AW-1:0];
            s = 8'd0;
            for (int i = 0; i < int'(v.len); i++) begin
                d = v.seed + 8'(i * 17);
                s = s + d;
                sb.push_back('{a, d, cyc + 1});
                a = a + 1'b1;
                send_byte(d);
            end
            check("last_pulse", {30'd0, ram_wre, ram_own}, 32'd3);
            @(posedge clk);
            #1;
            check("own_drop", {30'd0, ram_wre, ram_own}, 32'd0);
            send_byte(v.bad ? s + 8'd1 : s);
        end
        check("result", {28'd0, done, cpu_hold, err_code}, {28'd0, v.edone, v.ehold, v.eerr});
        check("own_idle", 32'(ram_own), 32'd0);
        @(posedge clk);
        #1;
        check("write_count", wr_count - w0, accept ? int'(v.len) : 0);
        // Noise in IDLE must leave the load result untouched
        send_byte(8'h00);
        send_byte(8'hFF);
        check("idle_hold", {27'd0, ram_own, done, cpu_hold, err_code}, {27'd0, 1'b0, v.edone, v.ehold, v.eerr});
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'd4,      8'h11, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{16'h0010, 16'd4,      8'h11, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[2] = '{16'h07FF, 16'd2,      8'h00, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'd0,      8'h00, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[4] = '{16'h07FE, 16'd2,      8'h5A, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[5] = '{16'hF800, 16'd5,      8'hA5, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{16'h0100, 16'h0701,   8'h00, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'hFFFF,   8'h00, 1'b0, 2'b01, 1'b0, 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {6'd0, ram_ce, ram_wre, ram_ad, ram_din, ram_own, cpu_hold, done, err_code},
              {6'd0, 1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b1, 1'b0, 2'b00});
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_after_reset", {27'd0, ram_own, cpu_hold, done, err_code}, 32'b01000);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Timeout after LHI
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        repeat (99) @(posedge clk);
        #1;
        check("pre_timeout", {27'd0, ram_own, cpu_hold, err_code}, 32'b1100);
        @(posedge clk);
        #1;
        check("timeout", {27'd0, ram_own, cpu_hold, done, err_code}, 32'b01011);
        run_vec(vecs[0]);

        // Reset mid-DATA, with a data byte arriving on the reset cycle
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'h04);
        sb.push_back('{11'h030, 8'h11, cyc + 1});
        send_byte(8'h11);
        sb.push_back('{11'h031, 8'h22, cyc + 1});
        send_byte(8'h22);
        reset = 1'b1;
        send_byte(8'h33);
        reset = 1'b0;
        check("reset_mid_data", {6'd0, ram_ce, ram_wre, ram_ad, ram_din, ram_own, cpu_hold, done, err_code},
              {6'd0, 1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b1, 1'b0, 2'b00});
        @(posedge clk);
        #1;
        run_vec(vecs[0]);
        run_vec(vecs[4]);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
